fpsu_ret_queue: RTL and testbench

- Retirement-side collector for the three FP store/shuffle return ports (u1/u3/u5), directly downstream of the FPSU pair.
- Each cycle it accepts up to three 14-bit return words, compacts them in port order into a circular FIFO, and drains one word per cycle to the retire logic over a valid/ready handshake.
- It also maintains sticky IEEE exception flags and raises a registered stall back to the FPSU issue stage before the FIFO can overflow.

---
 rtl/fpsu_ret_pkg.sv | 23 ++
 rtl/fpsu_ret_compact.sv | 40 ++++
 rtl/fpsu_ret_queue.sv | 158 +++++++++++++++
 tb/tb_fpsu_ret_queue.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fpsu_ret_pkg.sv
// Shared definitions for the FP store/shuffle return queue.
//   RET_W       : return word width. Bits [4:0] are IEEE flags, [13:5] opaque payload.
//   FLG_*       : bit index of each IEEE flag inside a return word.
//   ret_word_t  : return word type.
//   ret_flags() : extracts the 5-bit flag field {NV,DZ,OF,UF,NX} from a word.
package fpsu_ret_pkg;

  localparam int RET_W  = 14;
  localparam int FLG_W  = 5;

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  typedef logic [RET_W-1:0] ret_word_t;

  function automatic logic [FLG_W-1:0] ret_flags(input ret_word_t w);
    return {w[FLG_NV], w[FLG_DZ], w[FLG_OF], w[FLG_UF], w[FLG_NX]};
  endfunction

endpackage

// File: rtl/fpsu_ret_compact.sv
// Combinational port-order compaction of the three return ports.
//   u1/u3/u5_ret, *_en : incoming return words and their valids
//   lane0..2_data      : valid words packed toward lane 0, in order u1, u3, u5
//   lane_vld[i]        : lane i carries a word (thermometer code of n_in)
//   n_in               : number of valid incoming words (0..3)
import fpsu_ret_pkg::*;

module fpsu_ret_compact (
  input  logic [RET_W-1:0] u1_ret,
  input  logic             u1_ret_en,
  input  logic [RET_W-1:0] u3_ret,
  input  logic             u3_ret_en,
  input  logic [RET_W-1:0] u5_ret,
  input  logic             u5_ret_en,
  output logic [RET_W-1:0] lane0_data,
  output logic [RET_W-1:0] lane1_data,
  output logic [RET_W-1:0] lane2_data,
  output logic [2:0]       lane_vld,
  output logic [1:0]       n_in
);

  always_comb begin
    n_in = {1'b0, u1_ret_en} + {1'b0, u3_ret_en} + {1'b0, u5_ret_en};
    lane0_data = '0;
    lane1_data = '0;
    lane2_data = '0;
    case ({u1_ret_en, u3_ret_en, u5_ret_en})
      3'b100: lane0_data = u1_ret;
      3'b010: lane0_data = u3_ret;
      3'b001: lane0_data = u5_ret;
      3'b110: begin lane0_data = u1_ret; lane1_data = u3_ret; end
      3'b101: begin lane0_data = u1_ret; lane1_data = u5_ret; end
      3'b011: begin lane0_data = u3_ret; lane1_data = u5_ret; end
      3'b111: begin lane0_data = u1_ret; lane1_data = u3_ret; lane2_data = u5_ret; end
      default: ;
    endcase
    lane_vld = {n_in == 2'd3, n_in >= 2'd2, n_in >= 2'd1};
  end

endmodule

// File: rtl/fpsu_ret_queue.sv
// Retirement-side collector for the FPSU u1/u3/u5 return ports.
// Up to three words per cycle are compacted in port order into a circular FIFO
// and drained one per cycle to retire logic. Sticky IEEE flags and a sticky
// overflow error are kept, and a registered stall throttles the issue stage.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   u1/u3/u5_ret, *_en  : return words and valids
//   out_ret, out_vld    : FIFO head word and valid
//   out_rdy             : consumer accepts the head this cycle
//   stall               : registered; upstream issues no return next cycle while high
//   count               : occupied entries
//   flags_sticky        : accumulated {NV,DZ,OF,UF,NX} of accepted words
//   flags_clr           : clear sticky flags (new flags in the same cycle survive)
//   ovf_err             : sticky, set when an arriving word is dropped for lack of space
//
// Handshake: a word transfers on a cycle where out_vld && out_rdy at the
// rising edge; out_ret is stable while out_vld=1 and out_rdy=0, and out_rdy
// is ignored while out_vld=0.
//
// Optional feature (macro FPSU_RETQ_BYPASS_EN): with an empty FIFO and exactly
// one arriving word, that word is presented combinationally on out_ret; if
// taken that cycle it never enters the FIFO (flags still accumulate).
import fpsu_ret_pkg::*;

module fpsu_ret_queue #(
  parameter int DEPTH        = 8,
  parameter int STALL_MARGIN = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RET_W-1:0]         u1_ret,
  input  logic                     u1_ret_en,
  input  logic [RET_W-1:0]         u3_ret,
  input  logic                     u3_ret_en,
  input  logic [RET_W-1:0]         u5_ret,
  input  logic                     u5_ret_en,
  output logic [RET_W-1:0]         out_ret,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic [FLG_W-1:0]         flags_sticky,
  input  logic                     flags_clr,
  output logic                     ovf_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(STALL_MARGIN);

  logic [RET_W-1:0] mem_q [DEPTH];
  logic [RET_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             stall_q, stall_d;
  logic [FLG_W-1:0] flags_q, flags_d;
  logic             ovf_q, ovf_d;

  logic [RET_W-1:0] lane0_data, lane1_data, lane2_data;
  logic [RET_W-1:0] lane_data [3];
  logic [2:0]       lane_vld;
  logic [1:0]       n_in;

  logic             fifo_deq;
  logic             byp_take;
  logic [CW-1:0]    cap;
  logic [CW-1:0]    n_acc;
  logic [CW-1:0]    n_wr;
  logic [FLG_W-1:0] new_flags;

  fpsu_ret_compact u_compact (
    .u1_ret     (u1_ret),
    .u1_ret_en  (u1_ret_en),
    .u3_ret     (u3_ret),
    .u3_ret_en  (u3_ret_en),
    .u5_ret     (u5_ret),
    .u5_ret_en  (u5_ret_en),
    .lane0_data (lane0_data),
    .lane1_data (lane1_data),
    .lane2_data (lane2_data),
    .lane_vld   (lane_vld),
    .n_in       (n_in)
  );

  assign lane_data[0] = lane0_data;
  assign lane_data[1] = lane1_data;
  assign lane_data[2] = lane2_data;

  // Output view and bypass take.
`ifdef FPSU_RETQ_BYPASS_EN
  logic byp_hit;
  always_comb begin
    byp_hit  = (count_q == '0) && (n_in == 2'd1);
    byp_take = byp_hit && out_rdy;
    out_vld  = (count_q != '0) || byp_hit;
    out_ret  = byp_hit ? lane0_data : mem_q[rd_ptr_q];
  end
`else
  always_comb begin
    byp_take = 1'b0;
    out_vld  = (count_q != '0);
    out_ret  = mem_q[rd_ptr_q];
  end
`endif

  always_comb begin
    fifo_deq  = (count_q != '0) && out_rdy;
    // A slot freed by this cycle's dequeue is usable by this cycle's enqueue.
    cap       = DEPTH_C - count_q + CW'(fifo_deq);
    n_acc     = '0;
    new_flags = '0;
    mem_d     = mem_q;
    // Lanes are already in port order, so "first cap words" is lanes [0, cap).
    for (int i = 0; i < 3; i++) begin
      if (lane_vld[i] && (CW'(i) < cap)) begin
        new_flags = new_flags | ret_flags(lane_data[i]);
        if (!byp_take) mem_d[wr_ptr_q + PW'(i)] = lane_data[i];
        n_acc = n_acc + CW'(1);
      end
    end
    n_wr     = byp_take ? '0 : n_acc;
    wr_ptr_d = wr_ptr_q + n_wr[PW-1:0];
    rd_ptr_d = rd_ptr_q + PW'(fifo_deq);
    count_d  = count_q + n_wr - CW'(fifo_deq);
    ovf_d    = ovf_q || (CW'(n_in) > cap);
    stall_d  = (DEPTH_C - count_d) < MARGIN_C;
    flags_d  = (flags_clr ? '0 : flags_q) | new_flags;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= 1'b0;
      flags_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
      flags_q  <= flags_d;
      ovf_q    <= ovf_d;
    end
  end

  assign stall        = stall_q;
  assign count        = count_q;
  assign flags_sticky = flags_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_fpsu_ret_queue.sv
// Directed bench for fpsu_ret_queue (default build, DEPTH=8, STALL_MARGIN=3).
module tb_fpsu_ret_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [13:0] u1_ret = '0, u3_ret = '0, u5_ret = '0;
  logic        u1_ret_en = 1'b0, u3_ret_en = 1'b0, u5_ret_en = 1'b0;
  logic [13:0] out_ret;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic        stall;
  logic [3:0]  count;
  logic [4:0]  flags_sticky;
  logic        flags_clr = 1'b0;
  logic        ovf_err;

  int total = 0;
  int bad   = 0;

  // Scoreboard and reference state.
  logic [13:0] exp_q[$];
  logic [4:0]  m_flags = '0;
  logic        m_ovf   = 1'b0;
  logic        m_stall = 1'b0;

  fpsu_ret_queue #(.DEPTH(8), .STALL_MARGIN(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .u1_ret       (u1_ret),
    .u1_ret_en    (u1_ret_en),
    .u3_ret       (u3_ret),
    .u3_ret_en    (u3_ret_en),
    .u5_ret       (u5_ret),
    .u5_ret_en    (u5_ret_en),
    .out_ret      (out_ret),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .stall        (stall),
    .count        (count),
    .flags_sticky (flags_sticky),
    .flags_clr    (flags_clr),
    .ovf_err      (ovf_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic post_checks(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, "_vld"},   32'(out_vld), 32'(exp_q.size() != 0));
    chk({tag, "_stall"}, 32'(stall), 32'(m_stall));
    chk({tag, "_ovf"},   32'(ovf_err), 32'(m_ovf));
    chk({tag, "_flags"}, 32'(flags_sticky), 32'(m_flags));
    if (exp_q.size() != 0) chk({tag, "_head"}, 32'(out_ret), 32'(exp_q[0]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u1_ret_en = 1'b0; u3_ret_en = 1'b0; u5_ret_en = 1'b0;
    out_rdy = 1'b0; flags_clr = 1'b0;
    #2;
    chk("rst_async_count", 32'(count), 32'd0);
    chk("rst_async_vld",   32'(out_vld), 32'd0);
    exp_q.delete();
    m_flags = '0; m_ovf = 1'b0; m_stall = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_ret", 32'(out_ret), 32'd0);
    post_checks("rst");
  endtask

  // Driver: one clock of stimulus. Starts and ends at posedge+1.
  task automatic step(input logic e1, input logic [13:0] d1,
                      input logic e3, input logic [13:0] d3,
                      input logic e5, input logic [13:0] d5,
                      input logic rdy, input logic clr, input string tag);
    logic        en [3];
    logic [13:0] dd [3];
    logic        deq;
    logic [13:0] exp_w;
    int          cap;
    u1_ret_en = e1; u1_ret = d1;
    u3_ret_en = e3; u3_ret = d3;
    u5_ret_en = e5; u5_ret = d5;
    out_rdy = rdy; flags_clr = clr;
    #3;
    chk({tag, "_pre_vld"}, 32'(out_vld), 32'(exp_q.size() != 0));
    deq = (exp_q.size() != 0) && rdy;
    if (deq) begin
      exp_w = exp_q.pop_front();
      chk({tag, "_deq_data"}, 32'(out_ret), 32'(exp_w));
    end
    en[0] = e1; en[1] = e3; en[2] = e5;
    dd[0] = d1; dd[1] = d3; dd[2] = d5;
    cap = 8 - exp_q.size();
    if (clr) m_flags = '0;
    for (int i = 0; i < 3; i++) begin
      if (en[i]) begin
        if (cap > 0) begin
          exp_q.push_back(dd[i]);
          m_flags = m_flags | dd[i][4:0];
          cap--;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    m_stall = (8 - exp_q.size()) < 3;
    @(posedge clk); #1;
    post_checks(tag);
  endtask

  task automatic idle(input logic rdy, input string tag);
    step(1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 14'h0, rdy, 1'b0, tag);
  endtask

  function automatic logic [13:0] rnd();
    return 14'($urandom_range(0, 16383));
  endfunction

  initial begin
    #1;
    do_reset();

    // Single word, one-cycle latency, then drained.
    step(1'b1, 14'h0011, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b0, "single");
    chk("single_head_lit", 32'(out_ret), 32'h0011);
    chk("single_count_lit", 32'(count), 32'd1);
    idle(1'b1, "single_drain");
    chk("single_empty_lit", 32'(count), 32'd0);

    // u1 and u5 with u3 idle: compacted, drained in port order.
    step(1'b1, 14'h0100, 1'b0, 14'h0, 1'b1, 14'h0300, 1'b0, 1'b0, "gap");
    chk("gap_count_lit", 32'(count), 32'd2);
    idle(1'b1, "gap_d0");
    idle(1'b1, "gap_d1");
    idle(1'b1, "empty_rdy");

    // Two full bursts -> 6 entries and stall; third burst overflows.
    step(1'b1, rnd(), 1'b1, rnd(), 1'b1, rnd(), 1'b0, 1'b0, "burst0");
    step(1'b1, rnd(), 1'b1, rnd(), 1'b1, rnd(), 1'b0, 1'b0, "burst1");
    chk("burst_count6", 32'(count), 32'd6);
    chk("burst_stall", 32'(stall), 32'd1);
    step(1'b1, rnd(), 1'b1, rnd(), 1'b1, rnd(), 1'b0, 1'b0, "burst2");
    chk("ovf_count8", 32'(count), 32'd8);
    chk("ovf_set", 32'(ovf_err), 32'd1);
    idle(1'b1, "ovf_drain1");

    // Reset mid-operation discards queued entries.
    do_reset();

    // Fill exactly to 8, then full + dequeue + one arrival.
    step(1'b1, rnd(), 1'b1, rnd(), 1'b1, rnd(), 1'b0, 1'b0, "fill0");
    step(1'b1, rnd(), 1'b1, rnd(), 1'b1, rnd(), 1'b0, 1'b0, "fill1");
    step(1'b1, rnd(), 1'b0, 14'h0, 1'b1, rnd(), 1'b0, 1'b0, "fill2");
    chk("full_count", 32'(count), 32'd8);
    step(1'b1, rnd(), 1'b0, 14'h0, 1'b0, 14'h0, 1'b1, 1'b0, "full_deq_enq");
    chk("full_keep8", 32'(count), 32'd8);
    chk("full_no_ovf", 32'(ovf_err), 32'd0);
    for (int i = 0; i < 9; i++) idle(1'b1, "full_drain");

    // Sticky flags and clear-with-arrival.
    step(1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b1, "flg_clr");
    step(1'b0, 14'h0, 1'b1, 14'h0005, 1'b0, 14'h0, 1'b1, 1'b0, "flg_a");
    step(1'b0, 14'h0, 1'b1, 14'h0010, 1'b0, 14'h0, 1'b1, 1'b0, "flg_b");
    chk("flags_15", 32'(flags_sticky), 32'h15);
    step(1'b1, 14'h0002, 1'b0, 14'h0, 1'b0, 14'h0, 1'b1, 1'b1, "flg_clr_new");
    chk("flags_02", 32'(flags_sticky), 32'h02);
    idle(1'b1, "flg_drain");

    // Pointer wrap: 20 enqueue/dequeue pairs.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, rnd(), 1'b0, 14'h0, 1'b0, 14'h0, 1'b0, 1'b0, "wrap_enq");
      chk("wrap_cnt_le1", 32'(count <= 4'd1), 32'd1);
      idle(1'b1, "wrap_deq");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
